// File: rtl/uart_dpi.sv
// ---------------------------------------------------------------------------
// uart_dpi
// Simulation-side UART endpoint that sits on an MCU's UART pins. Host bytes
// are serialised onto tx_o; the rx_i line is deserialised into host bytes.
// Line format is fixed 8N1, LSB first, idle-high.
//
// Parameters
//   BAUD  line rate in bit/s
//   FREQ  clk_i frequency in Hz
//   NAME  label used in simulation printouts only
//
// Ports
//   clk_i           clock, all logic on the rising edge
//   rst_i           synchronous active-high reset
//   tx_o            serial out (idle 1)
//   rx_i            serial in, asynchronous to clk_i
//   tx_data_i       byte to send
//   tx_valid_i      send request
//   tx_ready_o      transmitter idle; byte accepted on tx_valid_i & tx_ready_o
//   rx_data_o       last correctly received byte, held until the next good one
//   rx_valid_o      one-cycle pulse, rx_data_o newly updated
//   rx_frame_err_o  one-cycle pulse, stop bit sampled low
// ---------------------------------------------------------------------------
module uart_dpi #(
  parameter int    BAUD = 256000,
  parameter int    FREQ = 100000000,
  parameter string NAME = "uart0"
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic       tx_o,
  input  logic       rx_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_frame_err_o
);

  localparam int CPB = FREQ / BAUD;
  localparam int TW  = $clog2(CPB + 1);

  localparam logic [TW-1:0] LP_BIT_LAST  = TW'(CPB - 1);
  localparam logic [TW-1:0] LP_HALF_LAST = TW'(CPB / 2 - 1);

  generate
    if (CPB < 4) begin : g_cpb_check
      $error("uart_dpi: FREQ/BAUD must be at least 4 clocks per bit");
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Transmitter
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  tx_state_t       r_tx_state;
  tx_state_t       w_tx_next;
  logic [TW-1:0]   r_tx_cnt;
  logic [2:0]      r_tx_bit;
  logic [7:0]      r_tx_shift;
  logic            r_tx_o;
  logic            w_tx_accept;
  logic            w_tx_bit_end;

  assign w_tx_accept  = tx_valid_i && (r_tx_state == TX_IDLE);
  assign w_tx_bit_end = (r_tx_cnt == LP_BIT_LAST);

  // NOTE: the next-state value gets its default before the case so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_IDLE:  if (w_tx_accept) w_tx_next = TX_START;
      TX_START: if (w_tx_bit_end) w_tx_next = TX_DATA;
      TX_DATA:  if (w_tx_bit_end && (r_tx_bit == 3'd7)) w_tx_next = TX_STOP;
      TX_STOP:  if (w_tx_bit_end) w_tx_next = TX_IDLE;
      default:  w_tx_next = TX_IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_o     <= 1'b1;
    end else begin
      r_tx_state <= w_tx_next;
      case (r_tx_state)
        TX_IDLE: begin
          r_tx_cnt <= '0;
          r_tx_bit <= '0;
          if (w_tx_accept) begin
            r_tx_shift <= tx_data_i;
            r_tx_o     <= 1'b0;
          end
        end
        TX_START: begin
          if (w_tx_bit_end) begin
            r_tx_cnt <= '0;
            r_tx_o   <= r_tx_shift[0];
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (w_tx_bit_end) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 3'd7) begin
              r_tx_bit <= '0;
              r_tx_o   <= 1'b1;
            end else begin
              // Bit 0 of the shifter is the bit on the line; the next one
              // to go out sits just above it.
              r_tx_bit   <= r_tx_bit + 1'b1;
              r_tx_o     <= r_tx_shift[1];
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (w_tx_bit_end) r_tx_cnt <= '0;
          else              r_tx_cnt <= r_tx_cnt + 1'b1;
        end
        default: begin
          r_tx_cnt <= '0;
          r_tx_o   <= 1'b1;
        end
      endcase
    end
  end

  assign tx_o       = r_tx_o;
  assign tx_ready_o = (r_tx_state == TX_IDLE);

  // -------------------------------------------------------------------------
  // Receiver
  // -------------------------------------------------------------------------
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  rx_state_t       r_rx_state;
  rx_state_t       w_rx_next;
  logic            r_sync1;
  logic            r_sync2;
  logic [TW-1:0]   r_rx_cnt;
  logic [2:0]      r_rx_bit;
  logic [7:0]      r_rx_shift;
  logic [7:0]      r_rx_data;
  logic            r_rx_valid;
  logic            r_rx_err;
  logic            w_rx_line;
  logic            w_rx_half_end;
  logic            w_rx_bit_end;

  assign w_rx_line     = r_sync2;
  assign w_rx_half_end = (r_rx_cnt == LP_HALF_LAST);
  assign w_rx_bit_end  = (r_rx_cnt == LP_BIT_LAST);

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (!w_rx_line) w_rx_next = RX_START;
      // A line that is high again at mid-start was a glitch.
      RX_START: if (w_rx_half_end) w_rx_next = w_rx_line ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_bit_end && (r_rx_bit == 3'd7)) w_rx_next = RX_STOP;
      RX_STOP:  if (w_rx_bit_end) w_rx_next = w_rx_line ? RX_IDLE : RX_BREAK;
      // After a framing error, hold off until the line is released so a
      // line held low is not mistaken for a stream of start bits.
      RX_BREAK: if (w_rx_line) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rx_state <= RX_IDLE;
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
    end else begin
      r_sync1    <= rx_i;
      r_sync2    <= r_sync1;
      r_rx_state <= w_rx_next;
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          r_rx_cnt <= '0;
          r_rx_bit <= '0;
        end
        RX_START: begin
          if (w_rx_half_end) r_rx_cnt <= '0;
          else               r_rx_cnt <= r_rx_cnt + 1'b1;
        end
        RX_DATA: begin
          if (w_rx_bit_end) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {w_rx_line, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) r_rx_bit <= '0;
            else                  r_rx_bit <= r_rx_bit + 1'b1;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (w_rx_bit_end) begin
            r_rx_cnt <= '0;
            if (w_rx_line) begin
              r_rx_data  <= r_rx_shift;
              r_rx_valid <= 1'b1;
            end else begin
              r_rx_err <= 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: begin
          r_rx_cnt <= '0;
          r_rx_bit <= '0;
        end
      endcase
    end
  end

  assign rx_data_o      = r_rx_data;
  assign rx_valid_o     = r_rx_valid;
  assign rx_frame_err_o = r_rx_err;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (r_rx_valid) $display("%s: 0x%02h '%c'", NAME, r_rx_data, r_rx_data);
  end
`endif

endmodule

// File: tb/tb_uart_dpi.sv
// ---------------------------------------------------------------------------
// tb_uart_dpi
// Directed bench for uart_dpi at BAUD=1, FREQ=8 (8 clocks per bit).
// Covers reset, a TX frame with bit-exact timing, loopback back-to-back RX,
// framing error with a held-low line, a start glitch and reset mid-frame.
// ---------------------------------------------------------------------------
module tb_uart_dpi;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_o;
  logic       rx_i;
  logic       rx_drv;
  logic       loop_en;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign rx_i = loop_en ? tx_o : rx_drv;

  uart_dpi #(
    .BAUD (1),
    .FREQ (8),
    .NAME ("uart0")
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .tx_o           (tx_o),
    .rx_i           (rx_i),
    .tx_data_i      (tx_data),
    .tx_valid_i     (tx_valid),
    .tx_ready_o     (tx_ready),
    .rx_data_o      (rx_data),
    .rx_valid_o     (rx_valid),
    .rx_frame_err_o (rx_err)
  );

  // RX event monitor: counts pulses and records data and cycle of each
  // rx_valid_o pulse.
  int         cyc  = 0;
  int         vcnt = 0;
  int         ecnt = 0;
  logic [7:0] vdata [16];
  int         vtime [16];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rx_valid === 1'b1) begin
      if (vcnt < 16) begin
        vdata[vcnt] = rx_data;
        vtime[vcnt] = cyc;
      end
      vcnt = vcnt + 1;
    end
    if (rx_err === 1'b1) ecnt = ecnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called at a negedge. Sends one byte and checks the whole frame: first and
  // last cycle of every bit, and tx_ready_o around the frame end. With poke
  // set, a second request is raised mid-frame and must be ignored.
  task automatic send_tx(input logic [7:0] b, input string tag, input bit poke);
    int   guard = 0;
    logic tx_log  [82];
    logic rdy_log [82];
    logic exp_bit;
    while (tx_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_ready_wait"}, 32'(tx_ready), 32'd1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    for (int c = 1; c <= 81; c++) begin
      @(negedge clk);
      tx_log[c]  = tx_o;
      rdy_log[c] = tx_ready;
      if (poke && c == 20) begin
        tx_data  = 8'h00;
        tx_valid = 1'b1;
      end
      if (poke && c == 21) tx_valid = 1'b0;
    end
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      exp_bit = 1'b0;
      else if (k == 9) exp_bit = 1'b1;
      else             exp_bit = b[k-1];
      check($sformatf("%s_bit%0d_first", tag, k), 32'(tx_log[k*CPB+1]), 32'(exp_bit));
      check($sformatf("%s_bit%0d_last", tag, k), 32'(tx_log[k*CPB+CPB]), 32'(exp_bit));
    end
    check({tag, "_busy_c1"},  32'(rdy_log[1]),  32'd0);
    check({tag, "_busy_c80"}, 32'(rdy_log[80]), 32'd0);
    check({tag, "_ready_c81"}, 32'(rdy_log[81]), 32'd1);
  endtask

  // Called at a negedge. Drives one frame on rx_i with a chosen stop level
  // and stop duration, then releases the line high.
  task automatic rx_send(input logic [7:0] b, input logic stop_val,
                         input int stop_len);
    rx_drv = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = stop_val;
    repeat (stop_len) @(negedge clk);
    rx_drv = 1'b1;
  endtask

  task automatic wait_valid(input int target, input string tag);
    int guard = 0;
    while (vcnt < target && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check(tag, 32'(vcnt >= target), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_v;
    int base_e;
    int gap;

    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    rx_drv   = 1'b1;
    loop_en  = 1'b0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tx_o",   32'(tx_o),     32'd1);
    check("rst_ready",  32'(tx_ready), 32'd1);
    check("rst_rx_vld", 32'(rx_valid), 32'd0);
    check("rst_rx_dat", 32'(rx_data),  32'h00);
    check("rst_rx_err", 32'(rx_err),   32'd0);
    rst = 1'b0;
    @(negedge clk);

    // TX 0xA5 with an ignored mid-frame request
    send_tx(8'hA5, "tx_a5", 1'b1);
    repeat (3) @(negedge clk);
    check("poke_not_queued_tx", 32'(tx_o),     32'd1);
    check("poke_not_queued_rdy", 32'(tx_ready), 32'd1);

    // Loopback, back-to-back 0x3C then 0xFF
    loop_en = 1'b1;
    base_v  = vcnt;
    base_e  = ecnt;
    send_tx(8'h3C, "lb_3c", 1'b0);
    send_tx(8'hFF, "lb_ff", 1'b0);
    wait_valid(base_v + 2, "lb_rx_timeout");
    repeat (20) @(negedge clk);
    check("lb_rx_count", 32'(vcnt - base_v), 32'd2);
    check("lb_rx_byte0", 32'(vdata[base_v]), 32'h3C);
    check("lb_rx_byte1", 32'(vdata[base_v+1]), 32'hFF);
    check("lb_no_ferr", 32'(ecnt - base_e), 32'd0);
    // One frame is ten bits plus the single cycle where tx_ready_o is high.
    gap = vtime[base_v+1] - vtime[base_v];
    check("lb_rx_spacing", 32'(gap == 10*CPB || gap == 10*CPB+1), 32'd1);
    loop_en = 1'b0;

    // Framing error: 0x55 with stop held low for 30 cycles
    base_v = vcnt;
    base_e = ecnt;
    rx_send(8'h55, 1'b0, 30);
    repeat (100) @(negedge clk);
    check("ferr_pulses",   32'(ecnt - base_e), 32'd1);
    check("ferr_no_valid", 32'(vcnt - base_v), 32'd0);
    check("ferr_data_held", 32'(rx_data), 32'hFF);
    base_v = vcnt;
    rx_send(8'h5A, 1'b1, CPB);
    wait_valid(base_v + 1, "ferr_recover_timeout");
    check("ferr_recover_data", 32'(rx_data), 32'h5A);

    // Glitch: rx low for 2 cycles in idle
    base_v = vcnt;
    base_e = ecnt;
    rx_drv = 1'b0;
    repeat (2) @(negedge clk);
    rx_drv = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_no_valid", 32'(vcnt - base_v), 32'd0);
    check("glitch_no_ferr",  32'(ecnt - base_e), 32'd0);
    rx_send(8'hA7, 1'b1, CPB);
    wait_valid(base_v + 1, "glitch_recover_timeout");
    check("glitch_recover_data", 32'(rx_data), 32'hA7);
    check("glitch_recover_nferr", 32'(ecnt - base_e), 32'd0);

    // Reset in the middle of a TX frame
    repeat (4) @(negedge clk);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    repeat (30) @(negedge clk);
    check("midrst_busy", 32'(tx_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_tx_o",  32'(tx_o),     32'd1);
    check("midrst_ready", 32'(tx_ready), 32'd1);
    check("midrst_rxdat", 32'(rx_data),  32'h00);
    rst = 1'b0;
    send_tx(8'h81, "post_rst", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
